display_scan_controller: RTL and testbench

Time-multiplexes one shared BCD-to-7-segment decoder (Display7seg) across NUM_DIGITS digits of the microwave timer display (MM:SS). The block latches a new digit set on request and applies it only at frame boundaries, so the display never tears. It scans the digits with a dead-time gap between them to prevent ghosting. It also blanks digits that are masked, out of range, or leading zeros.

---
 rtl/display_scan_controller.sv | 158 +++++++++++++++
 tb/tb_display_scan_controller.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/display_scan_controller.sv
// Scans NUM_DIGITS BCD digits through one shared external 7-segment decoder,
// with dead time between digits, frame-aligned data updates and digit blanking.
module display_scan_controller #(
    parameter int          NUM_DIGITS       = 4,
    parameter int          SHOW_CYCLES      = 1000,
    parameter int          DEAD_CYCLES      = 2,
    parameter logic [6:0]  SEG_BLANK        = 7'b0000000,
    parameter bit          DIGIT_ACTIVE_LOW = 1'b1,
    parameter bit          LZ_SUPPRESS      = 1'b1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]   blank_mask,
    output logic [3:0]              BCDout,
    input  logic [6:0]              BINin,
    output logic [6:0]              seg_out,
    output logic [NUM_DIGITS-1:0]   digit_sel,
    output logic                    frame_done
);

    localparam int MAX_CYCLES = (SHOW_CYCLES > DEAD_CYCLES) ? SHOW_CYCLES : DEAD_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES) + 1;
    localparam int IDX_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [NUM_DIGITS-1:0] SEL_OFF = DIGIT_ACTIVE_LOW ? '1 : '0;

    typedef enum logic [1:0] {IDLE, DEAD, SHOW} state_t;

    state_t                  state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [4*NUM_DIGITS-1:0] shadow_digits_q, shadow_digits_d;
    logic [NUM_DIGITS-1:0]   shadow_mask_q, shadow_mask_d;
    logic [4*NUM_DIGITS-1:0] active_digits_q, active_digits_d;
    logic [NUM_DIGITS-1:0]   active_mask_q, active_mask_d;
    logic [6:0]              seg_q, seg_d;
    logic [NUM_DIGITS-1:0]   sel_q, sel_d;
    logic                    frame_q, frame_d;

    logic [NUM_DIGITS-1:0]   digit_blank;
    logic [NUM_DIGITS-1:0]   sel_onehot;
    logic [NUM_DIGITS-1:0]   sel_on;

    // A digit is a leading zero when it and every more significant digit are 0.
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
        logic [3:0] digit;
        logic       upper_zero;
        assign digit       = active_digits_q[4*gi +: 4];
        assign upper_zero  = ~|active_digits_q[4*NUM_DIGITS-1:4*gi];
        assign digit_blank[gi] = active_mask_q[gi] | (digit > 4'd9) |
                                 (LZ_SUPPRESS && (gi > 0) && upper_zero);
    end

    assign BCDout     = active_digits_q[{idx_q, 2'b00} +: 4];
    assign seg_out    = seg_q;
    assign digit_sel  = sel_q;
    assign frame_done = frame_q;

    always_comb begin
        sel_onehot        = '0;
        sel_onehot[idx_q] = 1'b1;
        sel_on            = DIGIT_ACTIVE_LOW ? ~sel_onehot : sel_onehot;
    end

    always_comb begin
        state_d         = state_q;
        idx_d           = idx_q;
        cnt_d           = cnt_q;
        seg_d           = seg_q;
        sel_d           = SEL_OFF;
        frame_d         = 1'b0;
        active_digits_d = active_digits_q;
        active_mask_d   = active_mask_q;
        shadow_digits_d = load ? digits_in  : shadow_digits_q;
        shadow_mask_d   = load ? blank_mask : shadow_mask_q;

        case (state_q)
            IDLE: begin
                seg_d = SEG_BLANK;
                idx_d = '0;
                cnt_d = '0;
                if (enable) begin
                    state_d         = DEAD;
                    active_digits_d = shadow_digits_q;
                    active_mask_d   = shadow_mask_q;
                end
            end
            DEAD: begin
                if (cnt_q == CNT_W'(DEAD_CYCLES - 1)) begin
                    // An unknown blank decision falls through to the blank pattern.
                    if (!digit_blank[idx_q]) seg_d = BINin;
                    else                     seg_d = SEG_BLANK;
                    cnt_d   = '0;
                    state_d = SHOW;
                    sel_d   = sel_on;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            SHOW: begin
                if (cnt_q == CNT_W'(SHOW_CYCLES - 1)) begin
                    cnt_d   = '0;
                    state_d = DEAD;
                    if (idx_q == IDX_W'(NUM_DIGITS - 1)) begin
                        idx_d           = '0;
                        frame_d         = 1'b1;
                        active_digits_d = shadow_digits_q;
                        active_mask_d   = shadow_mask_q;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    sel_d = sel_on;
                end
            end
            default: state_d = IDLE;
        endcase

        if (!enable) begin
            state_d = IDLE;
            idx_d   = '0;
            cnt_d   = '0;
            seg_d   = SEG_BLANK;
            sel_d   = SEL_OFF;
            frame_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= IDLE;
            idx_q           <= '0;
            cnt_q           <= '0;
            shadow_digits_q <= '0;
            shadow_mask_q   <= '0;
            active_digits_q <= '0;
            active_mask_q   <= '0;
            seg_q           <= SEG_BLANK;
            sel_q           <= SEL_OFF;
            frame_q         <= 1'b0;
        end else begin
            state_q         <= state_d;
            idx_q           <= idx_d;
            cnt_q           <= cnt_d;
            shadow_digits_q <= shadow_digits_d;
            shadow_mask_q   <= shadow_mask_d;
            active_digits_q <= active_digits_d;
            active_mask_q   <= active_mask_d;
            seg_q           <= seg_d;
            sel_q           <= sel_d;
            frame_q         <= frame_d;
        end
    end

endmodule

// File: tb/tb_display_scan_controller.sv
// Scoreboard bench: a frame-position reference model predicts every cycle's
// outputs into a queue that a separate monitor drains and compares.
module tb_display_scan_controller;

    localparam int         N     = 4;
    localparam int         SHOW  = 4;
    localparam int         DEAD  = 1;
    localparam int         PER   = SHOW + DEAD;
    localparam int         FRAME = N * PER;
    localparam logic [6:0] BLANK = 7'b0000000;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         enable = 1'b0;
    logic         load = 1'b0;
    logic [15:0]  digits_in = '0;
    logic [3:0]   blank_mask = '0;
    logic [3:0]   BCDout;
    logic [6:0]   BINin;
    logic [6:0]   seg_out;
    logic [3:0]   digit_sel;
    logic         frame_done;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [6:0] seg;
        logic [3:0] sel;
        logic       fd;
        logic [3:0] bcd;
        bit         bcd_v;
    } exp_t;
    exp_t exp_q[$];

    // Reference model state: position within a frame rather than an FSM state.
    bit          m_run = 0;
    int          m_pos = 0;
    logic [15:0] m_sh_d = '0, m_ac_d = '0;
    logic [3:0]  m_sh_m = '0, m_ac_m = '0;
    logic [6:0]  m_seg = BLANK;

    display_scan_controller #(
        .NUM_DIGITS(N), .SHOW_CYCLES(SHOW), .DEAD_CYCLES(DEAD),
        .SEG_BLANK(BLANK), .DIGIT_ACTIVE_LOW(1'b1), .LZ_SUPPRESS(1'b1)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .load(load),
        .digits_in(digits_in), .blank_mask(blank_mask), .BCDout(BCDout),
        .BINin(BINin), .seg_out(seg_out), .digit_sel(digit_sel),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] seg7(input logic [3:0] v);
        case (v)
            4'd0: return 7'h3F;  4'd1: return 7'h06;  4'd2: return 7'h5B;
            4'd3: return 7'h4F;  4'd4: return 7'h66;  4'd5: return 7'h6D;
            4'd6: return 7'h7D;  4'd7: return 7'h07;  4'd8: return 7'h7F;
            4'd9: return 7'h6F;  default: return 7'h79;
        endcase
    endfunction

    always_comb BINin = seg7(BCDout);

    function automatic logic [6:0] ref_seg(input logic [15:0] d, input logic [3:0] m, input int k);
        logic [3:0] v;
        v = d[4*k +: 4];
        if (m[k]) return BLANK;
        if (v > 4'd9) return BLANK;
        if (k > 0 && (d >> (4*k)) == 16'd0) return BLANK;
        return seg7(v);
    endfunction

    task automatic model_edge(input bit r, input bit en, input bit ld,
                              input logic [15:0] d, input logic [3:0] m);
        exp_t e;
        logic fd;
        fd = 1'b0;
        if (r) begin
            m_run = 0; m_pos = 0; m_sh_d = '0; m_sh_m = '0;
            m_ac_d = '0; m_ac_m = '0; m_seg = BLANK;
        end else begin
            if (!en) begin
                m_run = 0; m_seg = BLANK;
            end else if (!m_run) begin
                m_run = 1; m_pos = 0; m_ac_d = m_sh_d; m_ac_m = m_sh_m;
            end else begin
                m_pos = (m_pos + 1) % FRAME;
                if (m_pos == 0) begin
                    m_ac_d = m_sh_d; m_ac_m = m_sh_m; fd = 1'b1;
                end
                if (m_pos % PER == DEAD) m_seg = ref_seg(m_ac_d, m_ac_m, m_pos / PER);
            end
            if (ld) begin
                m_sh_d = d; m_sh_m = m;
            end
        end
        e.seg   = m_seg;
        e.fd    = fd;
        e.sel   = 4'hF;
        if (m_run && (m_pos % PER) >= DEAD) e.sel[m_pos / PER] = 1'b0;
        e.bcd_v = m_run && (m_pos % PER) < DEAD;
        e.bcd   = m_ac_d[4*(m_pos / PER) +: 4];
        exp_q.push_back(e);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic step(input bit r, input bit en, input bit ld,
                        input logic [15:0] d, input logic [3:0] m);
        @(negedge clk);
        reset = r; enable = en; load = ld; digits_in = d; blank_mask = m;
        model_edge(r, en, ld, d, m);
        if (ld) $display("load digits=%h mask=%b en=%0d t=%0t", d, m, en, $time);
    endtask

    task automatic run(input int n, input bit en);
        for (int i = 0; i < n; i++) step(0, en, 0, 16'($urandom), 4'($urandom));
    endtask

    task automatic run_to_show(input int slot);
        int guard = 0;
        while (!(m_run && m_pos / PER == slot && m_pos % PER >= DEAD) && guard < 100) begin
            run(1, 1);
            guard++;
        end
    endtask

    function automatic logic [15:0] rand_digits();
        logic [15:0] d;
        int r;
        for (int k = 0; k < N; k++) begin
            r = $urandom_range(0, 9);
            if (r < 3)       d[4*k +: 4] = 4'd0;
            else if (r == 9) d[4*k +: 4] = 4'($urandom_range(10, 15));
            else             d[4*k +: 4] = 4'($urandom_range(1, 9));
        end
        return d;
    endfunction

    // Monitor: every cycle the DUT presents a fresh output set one step after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("seg_out", seg_out, e.seg);
                chk("digit_sel", digit_sel, e.sel);
                chk("frame_done", frame_done, e.fd);
                if (e.bcd_v) chk("BCDout", BCDout, e.bcd);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        step(1, 0, 0, '0, '0);
        step(1, 0, 0, '0, '0);
        // Basic scan of 0x1230
        step(0, 0, 1, 16'h1230, 4'b0000);
        run(45, 1);
        // Leading-zero suppression
        step(0, 1, 1, 16'h0005, 4'b0000);
        run(45, 1);
        step(0, 1, 1, 16'h0000, 4'b0000);
        run(45, 1);
        // Load mid-frame during digit 1 must not tear the current frame
        step(0, 1, 1, 16'h1230, 4'b0000);
        run(25, 1);
        run_to_show(1);
        step(0, 1, 1, 16'h4321, 4'b0000);
        run(45, 1);
        // Out-of-range digit plus mask
        step(0, 1, 1, 16'h7C85, 4'b0001);
        run(45, 1);
        // Drop enable during digit 2, then resume
        run_to_show(2);
        run(3, 0);
        run(30, 1);
        // Asynchronous reset in the middle of a SHOW phase
        run_to_show(1);
        @(negedge clk);
        load = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        chk("async_rst seg_out", seg_out, BLANK);
        chk("async_rst digit_sel", digit_sel, 4'hF);
        chk("async_rst frame_done", frame_done, 1'b0);
        chk("async_rst BCDout", BCDout, 4'h0);
        model_edge(1, enable, 0, digits_in, blank_mask);
        step(1, 1, 0, '0, '0);
        run(30, 1);
        step(0, 1, 1, 16'h0907, 4'b0000);
        run(45, 1);
        // Randomized traffic
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                run($urandom_range(1, 3), 0);
            end else if ($urandom_range(0, 14) == 0) begin
                step(0, 1, 1, rand_digits(),
                     ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000);
            end else begin
                run(1, 1);
            end
        end
        repeat (2) @(posedge clk);
        #2;
        chk("scoreboard drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
